// File: rtl/capture_pkg.sv
// capture_pkg: shared types for the DSP capture buffer.
//   state_t     - capture FSM states
//   trig_mode_t - trigger mode encodings driven on trig_mode
package capture_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        WAIT_TRIG,
        POST,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        TRIG_IMM  = 2'b00,
        TRIG_RISE = 2'b01,
        TRIG_FALL = 2'b10,
        TRIG_EXT  = 2'b11
    } trig_mode_t;

endpackage

// File: rtl/capture_ram.sv
// capture_ram: simple dual-port sample RAM, DW x 2**AW.
//   sys_clk      clock
//   we/waddr/wdata  synchronous write port
//   re/raddr     read request and address
//   q            registered read data, updated only when re is high
module capture_ram #(
    parameter int DW = 16,
    parameter int AW = 10
) (
    input  logic          sys_clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] q
);

    logic [DW-1:0] mem [2**AW];

    // NOTE: the array and its read register carry no reset so the tools can
    // map them onto block RAM; a reset would force them into flip-flops.
    always_ff @(posedge sys_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            q <= mem[raddr];
        end
    end

endmodule

// File: rtl/dsp_capture_buffer.sv
// dsp_capture_buffer: triggered capture of one signed DSP stream into RAM,
// with CPU readback of the N-sample window in oldest-first order.
//   sys_clk, rst_n     clock; rst_n is an asynchronous active-high reset
//   sample_in/sample_ce  sample stream and its qualifier
//   arm                one-cycle pulse starting a new capture
//   trig_mode/trig_level/ext_trig  trigger selection, threshold, external trigger
//   pretrig            samples kept ahead of the trigger sample
//   rd_en/rd_addr      read request, logical index (0 = oldest)
//   rd_data/rd_valid   registered read response (data is 0 unless DONE)
//   busy/triggered/done  capture status
module dsp_capture_buffer
    import capture_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 10
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    input  logic signed [DW-1:0] sample_in,
    input  logic                 sample_ce,
    input  logic                 arm,
    input  logic [1:0]           trig_mode,
    input  logic signed [DW-1:0] trig_level,
    input  logic                 ext_trig,
    input  logic [AW-1:0]        pretrig,
    input  logic                 rd_en,
    input  logic [AW-1:0]        rd_addr,
    output logic signed [DW-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 busy,
    output logic                 triggered,
    output logic                 done
);

    state_t                state;
    trig_mode_t            mode_q;
    logic [AW-1:0]         pretrig_q;
    logic signed [DW-1:0]  level_q;
    logic signed [DW-1:0]  prev;
    logic                  prev_valid;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         pre_cnt;
    logic [AW-1:0]         post_cnt;
    logic [AW-1:0]         start_ptr;
    logic                  rd_sel;
    logic [DW-1:0]         ram_q;
    logic                  take;
    logic                  hit;

    // A sample is stored only while capturing; arm in the same cycle wins.
    assign take = sample_ce && !arm &&
                  (state == PRE || state == WAIT_TRIG || state == POST);

    // Trigger condition against the current sample; signed compares.
    // NOTE: hit gets a default before the case so no latch is inferred.
    always_comb begin
        hit = 1'b0;
        case (mode_q)
            TRIG_IMM:  hit = 1'b1;
            TRIG_RISE: hit = prev_valid && (prev < level_q) && (sample_in >= level_q);
            TRIG_FALL: hit = prev_valid && (prev > level_q) && (sample_in <= level_q);
            TRIG_EXT:  hit = ext_trig;
            default:   hit = 1'b0;
        endcase
    end

    // NOTE: rst_n is active-high in this codebase despite its name, and all
    // sequential state uses non-blocking assignments so every register sees
    // the pre-edge values of the others.
    always_ff @(posedge sys_clk or posedge rst_n) begin
        if (rst_n) begin
            state      <= IDLE;
            mode_q     <= TRIG_IMM;
            pretrig_q  <= '0;
            level_q    <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
            wr_ptr     <= '0;
            pre_cnt    <= '0;
            post_cnt   <= '0;
            start_ptr  <= '0;
            busy       <= 1'b0;
            triggered  <= 1'b0;
            done       <= 1'b0;
        end else if (arm) begin
            pretrig_q  <= pretrig;
            mode_q     <= trig_mode_t'(trig_mode);
            level_q    <= trig_level;
            wr_ptr     <= '0;
            pre_cnt    <= '0;
            prev_valid <= 1'b0;
            triggered  <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b1;
            state      <= (pretrig != '0) ? PRE : WAIT_TRIG;
        end else if (take) begin
            wr_ptr     <= wr_ptr + 1'b1;
            prev       <= sample_in;
            prev_valid <= 1'b1;
            case (state)
                PRE: begin
                    pre_cnt <= pre_cnt + 1'b1;
                    if (pre_cnt + 1'b1 == pretrig_q) begin
                        state <= WAIT_TRIG;
                    end
                end
                WAIT_TRIG: begin
                    if (hit) begin
                        // Window starts pretrig samples before this one and
                        // runs N-1-pretrig samples past it.
                        start_ptr <= wr_ptr - pretrig_q;
                        post_cnt  <= ~pretrig_q;
                        triggered <= 1'b1;
                        if (&pretrig_q) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= POST;
                        end
                    end
                end
                POST: begin
                    post_cnt <= post_cnt - 1'b1;
                    if (post_cnt == AW'(1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Read response: valid always follows rd_en; data is masked to 0 unless
    // the read was issued while a completed window was held.
    always_ff @(posedge sys_clk or posedge rst_n) begin
        if (rst_n) begin
            rd_valid <= 1'b0;
            rd_sel   <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            rd_sel   <= rd_en && (state == DONE);
        end
    end

    assign rd_data = rd_sel ? ram_q : '0;

    capture_ram #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .sys_clk (sys_clk),
        .we      (take),
        .waddr   (wr_ptr),
        .wdata   (sample_in),
        .re      (rd_en),
        .raddr   (start_ptr + rd_addr),
        .q       (ram_q)
    );

endmodule

// File: tb/tb_dsp_capture_buffer.sv
// tb_dsp_capture_buffer: self-checking bench for dsp_capture_buffer.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// after the rising edge that produced them. Read responses are checked from
// a queue of expected words filled when each read is issued.
module tb_dsp_capture_buffer;

    localparam int DW = 16;
    localparam int AW = 10;
    localparam int N  = 1 << AW;

    logic                 sys_clk = 1'b0;
    logic                 rst_n   = 1'b1;
    logic signed [DW-1:0] sample_in = '0;
    logic                 sample_ce = 1'b0;
    logic                 arm = 1'b0;
    logic [1:0]           trig_mode = 2'b00;
    logic signed [DW-1:0] trig_level = '0;
    logic                 ext_trig = 1'b0;
    logic [AW-1:0]        pretrig = '0;
    logic                 rd_en = 1'b0;
    logic [AW-1:0]        rd_addr = '0;
    logic signed [DW-1:0] rd_data;
    logic                 rd_valid;
    logic                 busy;
    logic                 triggered;
    logic                 done;

    always #5 sys_clk = ~sys_clk;

    dsp_capture_buffer #(.DW(DW), .AW(AW)) dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .sample_in  (sample_in),
        .sample_ce  (sample_ce),
        .arm        (arm),
        .trig_mode  (trig_mode),
        .trig_level (trig_level),
        .ext_trig   (ext_trig),
        .pretrig    (pretrig),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .busy       (busy),
        .triggered  (triggered),
        .done       (done)
    );

    int            vectors = 0;
    int            miscompares = 0;
    logic [DW-1:0] exp_q[$];
    int            exp_win[N];
    int            sine[1300];

    task automatic do_arm(input int pt, input logic [1:0] md, input int lvl);
        arm        = 1'b1;
        pretrig    = AW'(pt);
        trig_mode  = md;
        trig_level = DW'(lvl);
        @(negedge sys_clk);
        arm = 1'b0;
    endtask

    // Reads logical indices lo..hi back to back, one per cycle.
    task automatic read_range(input int lo, input int hi, input bit zero, input string tag);
        logic [DW-1:0] e;
        for (int a = lo; a <= hi; a++) begin
            rd_en   = 1'b1;
            rd_addr = AW'(a);
            exp_q.push_back(zero ? '0 : DW'(exp_win[a]));
            @(negedge sys_clk);
            e = exp_q.pop_front();
            vectors++;
            if (rd_valid !== 1'b1 || rd_data !== e) begin
                miscompares++;
                $display("FAIL %s[%0d]: got valid=%b data=%0d, want valid=1 data=%0d",
                         tag, a, rd_valid, rd_data, $signed(e));
            end
        end
        rd_en = 1'b0;
        @(negedge sys_clk);
        vectors++;
        if (rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_valid_drop: got %b want 0", tag, rd_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        rst_n = 1'b0;
        @(negedge sys_clk);
        vectors++;
        if ({busy, triggered, done, rd_valid, rd_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%b trig=%b done=%b valid=%b data=%0d want all 0",
                     busy, triggered, done, rd_valid, rd_data);
        end
        // Samples with no arm since reset must not start anything.
        for (int n = 0; n < 4; n++) begin
            sample_ce = 1'b1;
            sample_in = DW'(n + 11);
            @(negedge sys_clk);
        end
        sample_ce = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL unarmed_samples: got busy=%b done=%b want 0 0", busy, done);
        end
        read_range(0, 3, 1'b1, "reset_rd");
    endtask

    task automatic test_ramp();
        arm = 1'b1; pretrig = '0; trig_mode = 2'b00; trig_level = '0;
        #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ramp_busy_early: got %b want 0", busy);
        end
        @(negedge sys_clk);
        arm = 1'b0;
        vectors++;
        if (busy !== 1'b1 || triggered !== 1'b0) begin
            miscompares++;
            $display("FAIL ramp_armed: got busy=%b trig=%b want 1 0", busy, triggered);
        end
        for (int n = 0; n < N; n++) begin
            sample_ce = 1'b1;
            sample_in = DW'(n);
            @(negedge sys_clk);
            if (n == 0) begin
                vectors++;
                if (triggered !== 1'b1) begin
                    miscompares++;
                    $display("FAIL ramp_trig: got %b want 1", triggered);
                end
            end
            if (n == N - 2) begin
                vectors++;
                if (done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL ramp_done_early: got %b want 0", done);
                end
            end
        end
        sample_ce = 1'b0;
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ramp_done: got done=%b busy=%b want 1 0", done, busy);
        end
        // Latency: no response in the issuing cycle, response one edge later.
        rd_en = 1'b1; rd_addr = AW'(5);
        #1;
        vectors++;
        if (rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_latency_early: got valid=%b want 0", rd_valid);
        end
        @(negedge sys_clk);
        rd_en = 1'b0;
        vectors++;
        if (rd_valid !== 1'b1 || rd_data !== 16'sd5) begin
            miscompares++;
            $display("FAIL rd_latency: got valid=%b data=%0d want 1 5", rd_valid, rd_data);
        end
        for (int k = 0; k < N; k++) exp_win[k] = k;
        read_range(0, N - 1, 1'b0, "ramp_rd");
    endtask

    task automatic test_rise_trigger();
        int  v = -50;
        bit  got_done = 1'b0;
        do_arm(16, 2'b01, 100);
        for (int i = 0; i < 1400 && !got_done; i++) begin
            sample_ce = 1'b1;
            sample_in = DW'(v);
            @(negedge sys_clk);
            sample_ce = 1'b0;
            if (v == 99 || v == 100) begin
                vectors++;
                if (triggered !== (v == 100)) begin
                    miscompares++;
                    $display("FAIL rise_trig_at_%0d: got %b want %b", v, triggered, v == 100);
                end
            end
            got_done = done;
            v++;
            repeat (2) @(negedge sys_clk);
        end
        vectors++;
        if (!got_done || v - 1 != 100 + N - 1 - 16) begin
            miscompares++;
            $display("FAIL rise_last_sample: got done=%b last=%0d want 1 %0d", got_done, v - 1, 100 + N - 17);
        end
        for (int k = 0; k < N; k++) exp_win[k] = 84 + k;
        read_range(0, N - 1, 1'b0, "rise_rd");
    endtask

    task automatic test_fall_trigger();
        int nt = -1;
        int nd = -1;
        for (int n = 0; n < 1300; n++)
            sine[n] = $rtoi(1000.0 * $sin(2.0 * 3.14159265358979 * n / 50.0));
        for (int n = N - 1; n < 1300 && nt < 0; n++)
            if (sine[n-1] > 0 && sine[n] <= 0) nt = n;
        do_arm(N - 1, 2'b10, 0);
        for (int n = 0; n < 1300 && nd < 0; n++) begin
            sample_ce = 1'b1;
            sample_in = DW'(sine[n]);
            @(negedge sys_clk);
            if (n == nt - 1) begin
                vectors++;
                if (done !== 1'b0 || triggered !== 1'b0) begin
                    miscompares++;
                    $display("FAIL fall_pre_trig: got done=%b trig=%b want 0 0", done, triggered);
                end
            end
            if (done === 1'b1) nd = n;
        end
        sample_ce = 1'b0;
        vectors++;
        if (nd != nt || triggered !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL fall_done_at_trigger: got done_after=%0d trig=%b busy=%b want %0d 1 0",
                     nd, triggered, busy, nt);
        end
        for (int k = 0; k < N; k++) exp_win[k] = sine[nt - (N - 1) + k];
        read_range(0, N - 1, 1'b0, "fall_rd");
    endtask

    task automatic test_ext_trigger();
        int last = -1;
        do_arm(8, 2'b11, 0);
        for (int n = 0; n < 1200 && last < 0; n++) begin
            sample_ce = 1'b1;
            sample_in = DW'(200 + n);
            ext_trig  = (n == 3 || n == 12);
            @(negedge sys_clk);
            sample_ce = 1'b0;
            ext_trig  = 1'b0;
            if (n == 3 || n == 11 || n == 12) begin
                vectors++;
                if (triggered !== (n == 12)) begin
                    miscompares++;
                    $display("FAIL ext_trig_after_%0d: got %b want %b", n, triggered, n == 12);
                end
            end
            if (n == 9) begin
                ext_trig = 1'b1;
                @(negedge sys_clk);
                ext_trig = 1'b0;
                vectors++;
                if (triggered !== 1'b0) begin
                    miscompares++;
                    $display("FAIL ext_unqualified: got %b want 0", triggered);
                end
            end
            if (done === 1'b1) last = n;
        end
        vectors++;
        if (last != 12 + N - 1 - 8) begin
            miscompares++;
            $display("FAIL ext_last_sample: got %0d want %0d", last, 12 + N - 9);
        end
        for (int k = 0; k < N; k++) exp_win[k] = 204 + k;
        read_range(0, 15, 1'b0, "ext_rd_lo");
        read_range(N - 8, N - 1, 1'b0, "ext_rd_hi");
    endtask

    task automatic test_rearm();
        int last = -1;
        do_arm(4, 2'b00, 0);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rearm_clear_done: got done=%b busy=%b want 0 1", done, busy);
        end
        for (int n = 0; n < 20; n++) begin
            sample_ce = 1'b1;
            sample_in = DW'(500 + n);
            @(negedge sys_clk);
        end
        vectors++;
        if (triggered !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rearm_in_post: got trig=%b busy=%b want 1 1", triggered, busy);
        end
        // Re-arm mid-POST with a coincident sample that must be dropped.
        sample_ce = 1'b1;
        sample_in = 16'sd9999;
        do_arm(2, 2'b00, 0);
        sample_ce = 1'b0;
        vectors++;
        if (triggered !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rearm_clear: got trig=%b done=%b busy=%b want 0 0 1", triggered, done, busy);
        end
        for (int n = 0; n < 1100 && last < 0; n++) begin
            sample_ce = 1'b1;
            sample_in = DW'(3000 + n);
            @(negedge sys_clk);
            if (n == 1 || n == 2) begin
                vectors++;
                if (triggered !== (n == 2)) begin
                    miscompares++;
                    $display("FAIL rearm_trig_after_%0d: got %b want %b", n, triggered, n == 2);
                end
            end
            if (done === 1'b1) last = n;
        end
        sample_ce = 1'b0;
        vectors++;
        if (last != N - 1) begin
            miscompares++;
            $display("FAIL rearm_last_sample: got %0d want %0d", last, N - 1);
        end
        for (int k = 0; k < N; k++) exp_win[k] = 3000 + k;
        read_range(0, 7, 1'b0, "rearm_rd_lo");
        read_range(N - 4, N - 1, 1'b0, "rearm_rd_hi");
    endtask

    task automatic test_reset_mid_capture();
        do_arm(0, 2'b00, 0);
        for (int n = 0; n < 10; n++) begin
            sample_ce = 1'b1;
            sample_in = DW'(7000 + n);
            @(negedge sys_clk);
        end
        sample_ce = 1'b0;
        rst_n   = 1'b1;
        rd_en   = 1'b1;
        rd_addr = AW'(3);
        @(negedge sys_clk);
        rd_en = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || triggered !== 1'b0 || rd_data !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_post: got busy=%b done=%b trig=%b data=%0d want 0 0 0 0",
                     busy, done, triggered, rd_data);
        end
        rst_n = 1'b0;
        @(negedge sys_clk);
        read_range(0, 3, 1'b1, "rst_rd_idle");
        do_arm(0, 2'b00, 0);
        for (int n = 0; n < 5; n++) begin
            sample_ce = 1'b1;
            sample_in = DW'(8000 + n);
            @(negedge sys_clk);
        end
        sample_ce = 1'b0;
        read_range(0, 2, 1'b1, "rst_rd_busy");
        for (int n = 5; n < N; n++) begin
            sample_ce = 1'b1;
            sample_in = DW'(8000 + n);
            @(negedge sys_clk);
        end
        sample_ce = 1'b0;
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_recapture_done: got %b want 1", done);
        end
        for (int k = 0; k < N; k++) exp_win[k] = 8000 + k;
        read_range(0, 3, 1'b0, "rst_rd_new_lo");
        read_range(N - 2, N - 1, 1'b0, "rst_rd_new_hi");
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_rise_trigger();
        test_fall_trigger();
        test_ext_trigger();
        test_rearm();
        test_reset_mid_capture();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
